// File: rtl/mainm_arbiter.sv
// rtl/mainm_arbiter.sv - two-master whole-transaction arbiter for the main-memory port
// Build option: MAINM_ARB_ROUNDROBIN_EN selects round-robin; undefined gives fixed m0 priority.
// Ports: clk, rst (synchronous, active-high)
//        m0_*/m1_*  : a, d, we, rd requests in; spo, ready completion out (granted master only)
//        mem_*      : registered a, d, we, rd to memory; mem_spo, mem_ready back from memory
//        grant      : one-hot owner {m1,m0}, 2'b00 when idle; busy high in BUSY or RESP
module mainm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_a,
    input  logic [DW-1:0] m0_d,
    input  logic          m0_we,
    input  logic          m0_rd,
    output logic [DW-1:0] m0_spo,
    output logic          m0_ready,
    input  logic [AW-1:0] m1_a,
    input  logic [DW-1:0] m1_d,
    input  logic          m1_we,
    input  logic          m1_rd,
    output logic [DW-1:0] m1_spo,
    output logic          m1_ready,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_spo,
    input  logic          mem_ready,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] mem_a_d;
    logic [DW-1:0] mem_d_d;
    logic          mem_we_d;
    logic          mem_rd_d;
    logic [1:0]    grant_d;
    logic [DW-1:0] spo_q;
    logic [DW-1:0] spo_d;
    logic          req0;
    logic          req1;
    logic          pick1;

    assign req0 = m0_rd | m0_we;
    assign req1 = m1_rd | m1_we;

`ifdef MAINM_ARB_ROUNDROBIN_EN
    // last_grant_q: 1 = m1 was granted last; reset to m1 so m0 wins the first contention
    logic last_grant_q;
    logic last_grant_d;

    assign pick1 = req1 & (~req0 | ~last_grant_q);
`else
    assign pick1 = req1 & ~req0;
`endif

    always_comb begin
        state_d  = state_q;
        mem_a_d  = mem_a;
        mem_d_d  = mem_d;
        mem_we_d = mem_we;
        mem_rd_d = mem_rd;
        grant_d  = grant;
        spo_d    = spo_q;
`ifdef MAINM_ARB_ROUNDROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d  = BUSY;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    mem_a_d  = pick1 ? m1_a : m0_a;
                    mem_d_d  = pick1 ? m1_d : m0_d;
                    mem_we_d = pick1 ? m1_we : m0_we;
                    // a write request masks a simultaneous read from the same master
                    mem_rd_d = pick1 ? (m1_rd & ~m1_we) : (m0_rd & ~m0_we);
`ifdef MAINM_ARB_ROUNDROBIN_EN
                    last_grant_d = pick1;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    spo_d    = mem_spo;
                    mem_we_d = 1'b0;
                    mem_rd_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 2'b00;
                mem_we_d = 1'b0;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mem_a   <= '0;
            mem_d   <= '0;
            mem_we  <= 1'b0;
            mem_rd  <= 1'b0;
            grant   <= 2'b00;
            spo_q   <= '0;
`ifdef MAINM_ARB_ROUNDROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            mem_a   <= mem_a_d;
            mem_d   <= mem_d_d;
            mem_we  <= mem_we_d;
            mem_rd  <= mem_rd_d;
            grant   <= grant_d;
            spo_q   <= spo_d;
`ifdef MAINM_ARB_ROUNDROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // completion is a pure decode of RESP, so it lasts exactly one cycle and only reaches the owner
    assign busy     = (state_q != IDLE);
    assign m0_ready = (state_q == RESP) & grant[0];
    assign m1_ready = (state_q == RESP) & grant[1];
    assign m0_spo   = m0_ready ? spo_q : '0;
    assign m1_spo   = m1_ready ? spo_q : '0;

endmodule

// File: tb/tb_mainm_arbiter.sv
// tb/tb_mainm_arbiter.sv - scoreboard bench for mainm_arbiter with random masters and memory
module tb_mainm_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra   [2];
    logic [DW-1:0] rdat [2];
    logic          rrd  [2];
    logic          rwe  [2];
    logic [AW-1:0] m0_a, m1_a, mem_a;
    logic [DW-1:0] m0_d, m1_d, m0_spo, m1_spo, mem_d, mem_spo;
    logic          m0_we, m0_rd, m1_we, m1_rd, m0_ready, m1_ready;
    logic          mem_we, mem_rd, mem_ready, busy;
    logic [1:0]    grant;
    logic [1:0]    rdy;
    logic [DW-1:0] spo_w [2];

    logic          mr_a = 1'b0, mr_d = 1'b0;
    logic [DW-1:0] spo_a = '0, spo_d = '0;
    logic          auto_mem = 1'b0;
    logic          stop = 1'b0;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    assign m0_a = ra[0];   assign m1_a = ra[1];
    assign m0_d = rdat[0]; assign m1_d = rdat[1];
    assign m0_rd = rrd[0]; assign m1_rd = rrd[1];
    assign m0_we = rwe[0]; assign m1_we = rwe[1];
    assign mem_ready = mr_a | mr_d;
    assign mem_spo   = mr_a ? spo_a : spo_d;
    assign rdy       = {m1_ready, m0_ready};
    assign spo_w[0]  = m0_spo;
    assign spo_w[1]  = m1_spo;

    mainm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_spo(mem_spo), .mem_ready(mem_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic flag(input string name);
        test_cnt++;
        fail_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push(input int i, input logic is_rd, input logic [DW-1:0] v);
        if (i == 0) q0.push_back({is_rd, v});
        else        q1.push_back({is_rd, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic rd, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        ra[i] = a; rdat[i] = d; rrd[i] = rd; rwe[i] = we;
    endtask

    task automatic drop(input int i);
        rrd[i] = 1'b0; rwe[i] = 1'b0;
    endtask

    task automatic hold_until_done(input logic [1:0] m);
        logic [1:0] mask;
        int n;
        mask = m;
        n = 0;
        while (mask != 2'b00 && n < 200) begin
            step();
            n++;
            for (int i = 0; i < 2; i++)
                if (mask[i] && rdy[i]) begin
                    drop(i);
                    mask[i] = 1'b0;
                end
        end
        if (mask != 2'b00) flag("hold_timeout");
    endtask

    task automatic run_master(input int i);
        int kind, n;
        logic [AW-1:0] a;
        while (!stop) begin
            repeat ($urandom_range(1, 4)) step();
            if (stop) break;
            kind = $urandom_range(0, 2);
            a = $urandom;
            req(i, kind != 1, kind != 0, a, $urandom);
            push(i, kind == 0, hash(a));
            n = 0;
            do begin
                step();
                n++;
            end while (!rdy[i] && n < 500);
            if (!rdy[i]) flag("master_timeout");
            drop(i);
        end
    endtask

    // memory responder: completes each strobe after a random 0..4 cycle delay
    initial begin
        int  dly;
        logic done;
        dly = 0;
        done = 1'b0;
        forever begin
            step();
            mr_a = 1'b0;
            if (auto_mem && (mem_rd || mem_we)) begin
                if (!done) begin
                    if (dly == 0) begin
                        mr_a  = 1'b1;
                        spo_a = mem_rd ? hash(mem_a) : DW'($urandom);
                        done  = 1'b1;
                    end else begin
                        dly--;
                    end
                end
            end else begin
                done = 1'b0;
                dly  = $urandom_range(0, 4);
            end
        end
    end

    // reference model + scoreboard monitor, sampled mid-cycle
    int            ph = 0;
    int            own = 0;
    int            lastg = 1;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0;
    logic          cur_we = 1'b0, cur_rd = 1'b0, chk_addr = 1'b1;

    always @(negedge clk) begin
        logic [DW:0] e;
        logic r0, r1;
        if (rst) begin
            ph = 0; lastg = 1; chk_addr = 1'b1;
            cur_a = '0; cur_d = '0; cur_we = 1'b0; cur_rd = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            chk("grant", grant, (ph == 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01));
            chk("busy", busy, ph != 0);
            chk("mem_we", mem_we, ph == 1 && cur_we);
            chk("mem_rd", mem_rd, ph == 1 && cur_rd && !cur_we);
            if (ph == 1 || chk_addr) begin
                chk("mem_a", mem_a, cur_a);
                chk("mem_d", mem_d, cur_d);
            end
            for (int i = 0; i < 2; i++) begin
                chk(i == 0 ? "m0_ready" : "m1_ready", rdy[i], ph == 2 && own == i);
                if (rdy[i] && ph == 2 && own == i) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        flag("scoreboard_empty");
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        if (e[DW]) chk(i == 0 ? "m0_spo" : "m1_spo", spo_w[i], e[DW-1:0]);
                    end
                end
                if (!(ph != 0 && own == i)) chk(i == 0 ? "m0_spo_idle" : "m1_spo_idle", spo_w[i], 0);
            end
            r0 = rrd[0] | rwe[0];
            r1 = rrd[1] | rwe[1];
            case (ph)
                0: if (r0 || r1) begin
`ifdef MAINM_ARB_ROUNDROBIN_EN
                    own = (r0 && r1) ? ((lastg == 0) ? 1 : 0) : (r1 ? 1 : 0);
`else
                    own = r0 ? 0 : 1;
`endif
                    lastg  = own;
                    cur_a  = ra[own];
                    cur_d  = rdat[own];
                    cur_we = rwe[own];
                    cur_rd = rrd[own];
                    chk_addr = 1'b0;
                    ph = 1;
                end
                1: if (mem_ready) ph = 2;
                default: ph = 0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rdat[i] = '0; rrd[i] = 1'b0; rwe[i] = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // single read with 3-cycle memory latency
        req(0, 1'b1, 1'b0, 32'h100, 32'h0);
        push(0, 1'b1, 32'hCAFEF00D);
        step(); step(); step();
        mr_d = 1'b1; spo_d = 32'hCAFEF00D;
        step();
        mr_d = 1'b0;
        chk("t1_ready", m0_ready, 1'b1);
        chk("t1_spo", m0_spo, 32'hCAFEF00D);
        drop(0);
        step();

        // single write from m1, rd&we on m0, then contention rounds with auto memory
        auto_mem = 1'b1;
        req(1, 1'b0, 1'b1, 32'h2000, 32'h12345678);
        push(1, 1'b0, 32'h0);
        hold_until_done(2'b10);
        step();
        req(0, 1'b1, 1'b1, 32'h44, 32'hA5A5_0001);
        push(0, 1'b0, 32'h0);
        hold_until_done(2'b01);
        step();
        for (int k = 0; k < 4; k++) begin
            req(0, 1'b1, 1'b0, 32'h1000 + k, 32'h0);
            req(1, 1'b0, 1'b1, 32'h3000 + k, 32'h7700 + k);
            push(0, 1'b1, hash(32'h1000 + k));
            push(1, 1'b0, 32'h0);
            hold_until_done(2'b11);
            step();
        end
        auto_mem = 1'b0;
        step();

        // reset while a read is in flight, then a stale mem_ready
        req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        push(0, 1'b1, 32'h0);
        step(); step();
        rst = 1'b1;
        drop(0);
        step();
        rst = 1'b0;
        chk("t5_mem_rd", mem_rd, 1'b0);
        chk("t5_grant", grant, 2'b00);
        mr_d = 1'b1; spo_d = 32'hBAD0BAD0;
        step();
        mr_d = 1'b0;
        step(); step();

        // spurious mem_ready in IDLE; inputs changed during BUSY must not reach mem_a/mem_d
        mr_d = 1'b1;
        step();
        mr_d = 1'b0;
        step();
        req(0, 1'b1, 1'b0, 32'h300, 32'h11);
        push(0, 1'b1, 32'h55);
        step();
        ra[0] = 32'hDEAD_BEEF; rdat[0] = 32'h9999_9999;
        step(); step();
        chk("t6_mem_a", mem_a, 32'h300);
        mr_d = 1'b1; spo_d = 32'h55;
        step();
        mr_d = 1'b0;
        chk("t6_ready", m0_ready, 1'b1);
        drop(0);
        step(); step();

        // randomized traffic from both masters
        auto_mem = 1'b1;
        fork
            run_master(0);
            run_master(1);
            begin
                repeat (3000) step();
                stop = 1'b1;
            end
        join
        repeat (5) step();
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
